uart_bus_sequencer: RTL and testbench
=====================================

# uart_bus_sequencer

Bus-side master for the memory-mapped UART peripheral (control register plus data register, selected by `reg_sel`/`addr`). It owns the peripheral's register port and drives the handshake autonomously:
- queues outgoing bytes in a TX FIFO, loads the data register and raises the send bit whenever the transmitter is free;
- polls the new-RX flag, reads received bytes into an RX FIFO and clears the flag.

It sits between a byte-stream client (valid/ready) and the UART top.

## Interface
- `TX_DEPTH`, 8, TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 8, RX FIFO entries; power of two, ≥2.
- `clk_i` in 1 — single clock; the 10 MHz system clock.
- `rst_i` in 1 — synchronous, active-high reset.
- `tx_data_i` in 8 — byte to transmit.
- `tx_valid_i` in 1 — `tx_data_i` valid.
- `tx_ready_o` out 1 — TX FIFO not full.
- `rx_data_o` out 8 — head of RX FIFO.
- `rx_valid_o` out 1 — RX FIFO not empty.
- `rx_ready_i` in 1 — client pops the RX head.
- `uart_wr_o` out 1 — register write strobe to the peripheral.
- `uart_reg_sel_o` out 1 — 0 = control register, 1 = data register.
- `uart_addr_o` out 1 — data register word: 0 = TX byte, 1 = RX byte.
- `uart_data_o` out 32 — write data.
- `uart_data_i` in 32 — combinational read data from the peripheral.
- `tx_level_o` out $clog2(TX_DEPTH)+1 — TX FIFO occupancy.
- `rx_overflow_o` out 1 — sticky; a received byte was dropped.
- `busy_o` out 1 — TX FIFO non-empty, or the last polled send bit was 1.

## Operation
- Peripheral control register layout:
  - bit0 = send: written 1 by the master; cleared by the peripheral when the frame is done.
  - bit1 = new_rx: set by the peripheral; cleared by a master write with bit1 = 0.
- FIFO transfers are valid/ready; a transfer happens on the edge where both are high.
  - A simultaneous push and pop is legal; the level is unchanged.
- States: IDLE, POLL, TX_LD, TX_GO, RX_RD, RX_ACK.
- IDLE: lasts one cycle after reset, then goes to POLL.
- POLL: `uart_wr_o`=0, `uart_reg_sel_o`=0. Samples `uart_data_i[1:0]` into `ctrl_q`. Next state:
  - RX_RD if bit1=1. RX has priority over TX.
  - Otherwise TX_LD if bit0=0 and the TX FIFO is non-empty.
  - Otherwise POLL.
- TX_LD: `uart_wr_o`=1, `uart_reg_sel_o`=1, `uart_addr_o`=0, `uart_data_o`={24'h0, TX head}. Pops the TX FIFO. Next: TX_GO.
- TX_GO: `uart_wr_o`=1, `uart_reg_sel_o`=0, `uart_data_o`=32'h1. Next: POLL.
- RX_RD: `uart_wr_o`=0, `uart_reg_sel_o`=1, `uart_addr_o`=1. Captures `uart_data_i[7:0]`.
  - RX FIFO not full: push the byte.
  - RX FIFO full: drop the byte and set `rx_overflow_o`.
  - Next: RX_ACK.
- RX_ACK: `uart_wr_o`=1, `uart_reg_sel_o`=0, `uart_data_o`={30'h0, 1'b0, `ctrl_q[0]`}. This preserves an in-flight send bit. Next: POLL.
- `rx_overflow_o` is cleared only by reset.
- Reset mid-operation:
  - the state returns to IDLE;
  - both FIFOs are emptied;
  - all strobes drop in the same cycle the reset is sampled.
  - A peripheral send already in flight is not cancelled.

## Timing
- Reset values:
  - `tx_ready_o`=1, `rx_valid_o`=0, `rx_data_o`=0;
  - `uart_wr_o`=0, `uart_reg_sel_o`=0, `uart_addr_o`=0, `uart_data_o`=0;
  - `tx_level_o`=0, `rx_overflow_o`=0, `busy_o`=0.
- Peripheral outputs are registered and decoded from the current state.
- TX latency: a byte accepted at edge N with the sequencer in POLL and send=0 produces:
  - TX_LD in cycle N+2;
  - TX_GO in cycle N+3;
  - send bit set at edge N+4.
- RX service costs 2 cycles (RX_RD, RX_ACK). RX data is visible on `rx_data_o` the cycle after the RX_RD edge.
- Back-to-back TX: the next TX_LD happens only after a POLL that observes send=0.
- No write is ever issued in POLL or RX_RD.

## Configuration
- `UART_SEQ_RX_EN` defined: RX FIFO, RX_RD and RX_ACK are present.
- `UART_SEQ_RX_EN` undefined:
  - POLL ignores bit1;
  - RX states and the RX FIFO are removed;
  - `rx_valid_o`=0, `rx_data_o`=0, `rx_overflow_o`=0 constant; `rx_ready_i` is ignored.

## Test plan
- Reset, then push 8'hA5 → TX_LD writes 32'h0000_00A5 to data addr 0, TX_GO writes 32'h1 to control, send bit set at edge N+4.
- Push 9 bytes with DEPTH=8 while the model holds send=1 → `tx_ready_o`=0 after 8 bytes. After the model clears send, the bytes go out in order; no TX_LD happens while send=1.
- Model sets new_rx with data byte 8'h3C and send=1 → RX_RD then RX_ACK writes 32'h1, `rx_valid_o`=1 with `rx_data_o`=8'h3C. RX is served before a pending TX byte.
- Hold `rx_ready_i`=0 and deliver 9 RX bytes → the 9th is dropped, `rx_overflow_o`=1 sticky, the FIFO holds the first 8.
- Assert `rst_i` during TX_GO → `uart_wr_o`=0 next cycle, `tx_level_o`=0, IDLE then POLL.
- Build without `UART_SEQ_RX_EN`, set new_rx → no read or write of RX registers; TX still functions.

Source files
------------

// File: rtl/uart_bus_sequencer.sv
// uart_bus_sequencer: autonomous register-port master for the UART peripheral with TX/RX byte FIFOs
// Ports: clk_i/rst_i clock and sync active-high reset; tx_data_i/tx_valid_i/tx_ready_o byte stream in;
//   rx_data_o/rx_valid_o/rx_ready_i byte stream out; uart_wr_o/uart_reg_sel_o/uart_addr_o/uart_data_o/
//   uart_data_i peripheral register port; tx_level_o TX occupancy; rx_overflow_o sticky RX drop flag;
//   busy_o TX bytes pending or last polled send bit set.
// Build option: define UART_SEQ_RX_EN to include the RX path (RX FIFO, RX_RD, RX_ACK).
module uart_bus_sequencer #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      uart_wr_o,
  output logic                      uart_reg_sel_o,
  output logic                      uart_addr_o,
  output logic [31:0]               uart_data_o,
  input  logic [31:0]               uart_data_i,
  output logic [$clog2(TX_DEPTH):0] tx_level_o,
  output logic                      rx_overflow_o,
  output logic                      busy_o
);
  localparam int TW = $clog2(TX_DEPTH);
`ifdef UART_SEQ_RX_EN
  typedef enum logic [2:0] {IDLE, POLL, TX_LD, TX_GO, RX_RD, RX_ACK} state_e;
`else
  typedef enum logic [1:0] {IDLE, POLL, TX_LD, TX_GO} state_e;
`endif
  state_e state_q, state_d;
  logic [1:0] ctrl_q;
  logic poll_ok_q, tx_avail_q, in_rd, in_ack;
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [TW-1:0] tx_wr_q, tx_rd_q;
  logic [TW:0] tx_cnt_q;
  logic tx_push, tx_pop;
  assign tx_ready_o = tx_cnt_q != (TW+1)'(TX_DEPTH);
  assign tx_push = tx_valid_i && tx_ready_o;
  assign tx_pop = state_q == TX_LD;
  assign tx_level_o = tx_cnt_q;
  assign busy_o = tx_cnt_q != '0 || ctrl_q[0];
  always_ff @(posedge clk_i)
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data_i;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_q + TW'(tx_push);
      tx_rd_q <= tx_rd_q + TW'(tx_pop);
      tx_cnt_q <= tx_cnt_q + (TW+1)'(tx_push) - (TW+1)'(tx_pop);
    end
  // The POLL decision works from a registered snapshot of the control bits and TX occupancy,
  // keeping the peripheral's combinational read path out of the next-state logic. The snapshot
  // is only trusted once it was taken in a POLL cycle (poll_ok_q), so stale send bits from
  // before a write are never acted upon.
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      poll_ok_q <= 1'b0;
      tx_avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_ok_q <= state_q == POLL;
      tx_avail_q <= tx_cnt_q != '0;
      if (state_q == POLL) ctrl_q <= uart_data_i[1:0];
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = POLL;
      POLL: begin
        state_d = (poll_ok_q && !ctrl_q[0] && tx_avail_q) ? TX_LD : POLL;
`ifdef UART_SEQ_RX_EN
        if (poll_ok_q && ctrl_q[1]) state_d = RX_RD;
`endif
      end
      TX_LD:  state_d = TX_GO;
      TX_GO:  state_d = POLL;
`ifdef UART_SEQ_RX_EN
      RX_RD:  state_d = RX_ACK;
      RX_ACK: state_d = POLL;
`endif
      default: state_d = IDLE;
    endcase
  end
  assign uart_wr_o = state_q == TX_LD || state_q == TX_GO || in_ack;
  assign uart_reg_sel_o = state_q == TX_LD || in_rd;
  assign uart_addr_o = in_rd;
  // RX_ACK rewrites the snapshot send bit so an in-flight frame is not cancelled
  assign uart_data_o = state_q == TX_LD ? {24'h0, tx_mem_q[tx_rd_q]} :
                       state_q == TX_GO ? 32'h1 :
                       in_ack ? {31'h0, ctrl_q[0]} : 32'h0;
`ifdef UART_SEQ_RX_EN
  localparam int RW = $clog2(RX_DEPTH);
  logic [7:0] rx_mem_q [RX_DEPTH];
  logic [RW-1:0] rx_wr_q, rx_rd_q;
  logic [RW:0] rx_cnt_q;
  logic rx_full, rx_push, rx_pop, ovf_q;
  logic unused_hi;
  assign in_rd = state_q == RX_RD;
  assign in_ack = state_q == RX_ACK;
  assign rx_full = rx_cnt_q == (RW+1)'(RX_DEPTH);
  assign rx_push = in_rd && !rx_full;
  assign rx_pop = rx_valid_o && rx_ready_i;
  assign rx_valid_o = rx_cnt_q != '0;
  assign rx_data_o = rx_valid_o ? rx_mem_q[rx_rd_q] : 8'h0;
  assign rx_overflow_o = ovf_q;
  assign unused_hi = ^uart_data_i[31:8];
  always_ff @(posedge clk_i)
    if (rx_push) rx_mem_q[rx_wr_q] <= uart_data_i[7:0];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      rx_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rx_wr_q <= rx_wr_q + RW'(rx_push);
      rx_rd_q <= rx_rd_q + RW'(rx_pop);
      rx_cnt_q <= rx_cnt_q + (RW+1)'(rx_push) - (RW+1)'(rx_pop);
      ovf_q <= ovf_q || (in_rd && rx_full);
    end
`else
  logic unused_rx;
  assign in_rd = 1'b0;
  assign in_ack = 1'b0;
  assign rx_valid_o = 1'b0;
  assign rx_data_o = 8'h0;
  assign rx_overflow_o = 1'b0;
  assign unused_rx = ^{rx_ready_i, ctrl_q[1], uart_data_i[31:2], RX_DEPTH != 0};
`endif
endmodule

// File: tb/tb_uart_bus_sequencer.sv
// tb_uart_bus_sequencer: scoreboard bench with a behavioural UART register model
module tb_uart_bus_sequencer;
  typedef struct packed {logic sel; logic addr; logic [31:0] data;} wr_t;
  logic clk = 1'b0, rst_i = 1'b1;
  logic [7:0] tx_data_i = 8'h0;
  logic tx_valid_i = 1'b0, rx_ready_i = 1'b0;
  logic tx_ready_o, rx_valid_o, uart_wr_o, uart_reg_sel_o, uart_addr_o, rx_overflow_o, busy_o;
  logic [7:0] rx_data_o;
  logic [31:0] uart_data_o, uart_data_i;
  logic [3:0] tx_level_o;
  logic send = 1'b0, new_rx = 1'b0, hold_send = 1'b0, set_send = 1'b0, inj_valid = 1'b0;
  logic [7:0] inj_byte = 8'h0, rx_byte = 8'h0, tx_byte = 8'h0;
  int timer = 0;
  int passed = 0, total = 0, wr_seen = 0, rd_seen = 0, w0 = 0;
  bit found;
  wr_t exp_wr[$];
  logic [7:0] exp_rx[$];

  always #50 clk = ~clk;

  uart_bus_sequencer #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .uart_wr_o(uart_wr_o), .uart_reg_sel_o(uart_reg_sel_o), .uart_addr_o(uart_addr_o),
    .uart_data_o(uart_data_o), .uart_data_i(uart_data_i),
    .tx_level_o(tx_level_o), .rx_overflow_o(rx_overflow_o), .busy_o(busy_o)
  );

  // peripheral: combinational read, registered writes, frame completes 6 cycles after send unless held
  assign uart_data_i = uart_reg_sel_o ? (uart_addr_o ? {24'h0, rx_byte} : {24'h0, tx_byte})
                                      : {30'h0, new_rx, send};
  always @(posedge clk) begin
    if (uart_wr_o && uart_reg_sel_o && !uart_addr_o) tx_byte <= uart_data_o[7:0];
    if (uart_wr_o && !uart_reg_sel_o) begin
      send <= uart_data_o[0];
      new_rx <= new_rx & uart_data_o[1];
      timer <= 5;
    end else if (send && !hold_send) begin
      if (timer == 0) send <= 1'b0;
      else timer <= timer - 1;
    end
    if (set_send) begin
      send <= 1'b1;
      timer <= 5;
    end
    if (inj_valid) begin
      new_rx <= 1'b1;
      rx_byte <= inj_byte;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (uart_reg_sel_o && uart_addr_o && !uart_wr_o) rd_seen++;
    if (uart_wr_o) begin
      wr_seen++;
      if (uart_reg_sel_o && !uart_addr_o) chk("ld_while_send", send, 0);
      if (exp_wr.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%0h required none",
                 uart_reg_sel_o, uart_addr_o, uart_data_o);
      end else begin
        e = exp_wr.pop_front();
        chk("bus_write", {uart_reg_sel_o, uart_reg_sel_o & uart_addr_o, uart_data_o},
            {e.sel, e.sel & e.addr, e.data});
      end
    end
    if (rx_valid_o && rx_ready_i) begin
      if (exp_rx.size() == 0) begin
        total++;
        $display("FAIL unexpected_rx: got %0h required none", rx_data_o);
      end else chk("rx_byte", rx_data_o, exp_rx.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_tx(logic [7:0] b);
    exp_wr.push_back({1'b1, 1'b0, 24'h0, b});
    exp_wr.push_back({1'b0, 1'b0, 32'h1});
  endtask

  task automatic push_byte(logic [7:0] b);
    tx_valid_i = 1'b1;
    tx_data_i = b;
    step();
    tx_valid_i = 1'b0;
  endtask

  task automatic inject(logic [7:0] b);
    inj_valid = 1'b1;
    inj_byte = b;
    step();
    inj_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int k = 0;
    while (exp_wr.size() != 0 && k < 3000) begin
      step();
      k++;
    end
    chk(name, exp_wr.size(), 0);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_rx", {rx_valid_o, rx_data_o, rx_overflow_o}, 0);
    chk("rst_bus", {uart_wr_o, uart_reg_sel_o, uart_addr_o, uart_data_o}, 0);
    chk("rst_level_busy", {tx_level_o, busy_o}, 0);
    rst_i = 1'b0;
    repeat (4) step();
    // single byte latency: accepted at edge N
    exp_tx(8'hA5);
    push_byte(8'hA5);
    chk("a5_cycN", {uart_wr_o, tx_level_o}, {1'b0, 4'd1});
    step();
    chk("a5_cycN1", uart_wr_o, 0);
    step();
    chk("a5_tx_ld", {uart_wr_o, uart_reg_sel_o, uart_addr_o, uart_data_o}, {3'b110, 32'hA5});
    step();
    chk("a5_tx_go", {uart_wr_o, uart_reg_sel_o, uart_data_o, send}, {2'b10, 32'h1, 1'b0});
    step();
    chk("a5_send_set", {send, uart_wr_o}, 2'b10);
    step();
    chk("a5_busy", busy_o, 1);
    drain("a5_drain");
    repeat (12) step();
    chk("a5_idle", {busy_o, send}, 0);
    // fill the TX FIFO while the frame is held in flight
    hold_send = 1'b1;
    set_send = 1'b1;
    step();
    set_send = 1'b0;
    repeat (3) step();
    w0 = wr_seen;
    for (int i = 0; i < 8; i++) begin
      exp_tx(8'(8'h10 + i));
      push_byte(8'(8'h10 + i));
    end
    chk("full_level", {tx_level_o, tx_ready_o}, {4'd8, 1'b0});
    tx_valid_i = 1'b1;
    tx_data_i = 8'h18;
    repeat (2) step();
    tx_valid_i = 1'b0;
    chk("full_hold", tx_level_o, 8);
    repeat (5) step();
    chk("no_ld_while_send", wr_seen, w0);
    chk("full_busy", busy_o, 1);
    hold_send = 1'b0;
    drain("burst_drain");
    chk("burst_level", tx_level_o, 0);
    repeat (12) step();
`ifdef UART_SEQ_RX_EN
    // RX while send=1 and a TX byte waits
    hold_send = 1'b1;
    set_send = 1'b1;
    step();
    set_send = 1'b0;
    repeat (3) step();
    exp_wr.push_back({1'b0, 1'b0, 32'h1});
    exp_tx(8'h77);
    tx_valid_i = 1'b1;
    tx_data_i = 8'h77;
    inj_valid = 1'b1;
    inj_byte = 8'h3C;
    step();
    tx_valid_i = 1'b0;
    inj_valid = 1'b0;
    repeat (8) step();
    chk("rx_ack_done", exp_wr.size(), 2);
    chk("rx_head", {rx_valid_o, rx_data_o}, {1'b1, 8'h3C});
    chk("rx_flags", {new_rx, send}, 2'b01);
    hold_send = 1'b0;
    drain("rx_tx_drain");
    exp_rx.push_back(8'h3C);
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
    chk("rx_popped", rx_valid_o, 0);
    repeat (12) step();
    // RX and TX requested together, send=0: RX first
    exp_wr.push_back({1'b0, 1'b0, 32'h0});
    exp_tx(8'h55);
    exp_rx.push_back(8'h66);
    tx_valid_i = 1'b1;
    tx_data_i = 8'h55;
    inj_valid = 1'b1;
    inj_byte = 8'h66;
    step();
    tx_valid_i = 1'b0;
    inj_valid = 1'b0;
    drain("prio_drain");
    chk("prio_rx", {rx_valid_o, rx_data_o}, {1'b1, 8'h66});
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
    repeat (12) step();
    // overflow: 9 bytes with no client pops
    for (int i = 0; i < 9; i++) begin
      exp_wr.push_back({1'b0, 1'b0, 32'h0});
      if (i < 8) exp_rx.push_back(8'(8'hC0 + i));
      inject(8'(8'hC0 + i));
      repeat (7) step();
      if (i == 7) chk("ovf_before", {rx_overflow_o, rx_valid_o}, 2'b01);
    end
    chk("ovf_set", {rx_overflow_o, rx_valid_o, rx_data_o}, {2'b11, 8'hC0});
    chk("rx_reads", rd_seen, 11);
    rx_ready_i = 1'b1;
    repeat (8) step();
    rx_ready_i = 1'b0;
    chk("ovf_sticky", {rx_overflow_o, rx_valid_o}, 2'b10);
    chk("rx_all_popped", exp_rx.size(), 0);
    repeat (4) step();
`endif
    // reset while in TX_GO with a second byte queued
    exp_tx(8'h42);
    push_byte(8'h42);
    push_byte(8'h43);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (uart_wr_o && !uart_reg_sel_o) found = 1'b1;
      else step();
    end
    chk("rst_found_go", found, 1);
    rst_i = 1'b1;
    step();
    chk("rst_mid_bus", {uart_wr_o, uart_data_o}, 0);
    chk("rst_mid_level", {tx_level_o, tx_ready_o}, {4'd0, 1'b1});
    rst_i = 1'b0;
    step();
    chk("rst_idle", uart_wr_o, 0);
    exp_tx(8'h99);
    push_byte(8'h99);
    drain("post_rst_drain");
    repeat (12) step();
`ifndef UART_SEQ_RX_EN
    // RX path absent: new_rx is ignored, TX keeps working
    w0 = wr_seen;
    inject(8'h3C);
    repeat (10) step();
    chk("norx_no_write", wr_seen, w0);
    chk("norx_no_read", rd_seen, 0);
    chk("norx_outputs", {rx_valid_o, rx_data_o, rx_overflow_o}, 0);
    exp_tx(8'h5A);
    push_byte(8'h5A);
    drain("norx_tx_drain");
    repeat (4) step();
`endif
    chk("scoreboard_empty", {exp_wr.size(), exp_rx.size()}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end
endmodule
